// File: rtl/tick_sequencer.sv
// -----------------------------------------------------------------------------
// tick_sequencer
//
// Gates ticks from an asynchronous source (assync) into single-cycle tick_en
// pulses in the clk domain, under control of four single-cycle requests:
//   start - toggles between IDLE and free-running RUN
//   step  - delivers exactly one tick, then returns to IDLE
//   burst - delivers BURST_N ticks, then returns to IDLE
//   stop  - aborts any operation (and suppresses a coincident tick)
// Requests that arrive in the same cycle resolve as stop > start > burst > step.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   start       in   run/pause toggle request (1-cycle pulse)
//   step        in   single-tick request (1-cycle pulse)
//   burst       in   BURST_N-tick request (1-cycle pulse)
//   stop        in   abort request (1-cycle pulse)
//   assync      in   asynchronous tick source
//   tick_en     out  one-cycle pulse per delivered tick (registered)
//   state       out  2-bit state: IDLE=00 RUN=01 STEP=10 BURST=11
//   busy        out  state != IDLE (combinational)
//   tick_count  out  delivered-tick count, wraps silently
// -----------------------------------------------------------------------------
module tick_sequencer #(
  parameter int CNT_W   = 8,
  parameter int BURST_N = 16   // legal range 1..255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             burst,
  input  logic             stop,
  input  logic             assync,
  output logic             tick_en,
  output logic [1:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } state_e;

  localparam logic [7:0] BURST_LOAD = 8'(BURST_N);

  state_e           state_q, state_d;
  logic [7:0]       remaining_q, remaining_d;
  logic             tick_en_q, tick_en_d;
  logic [CNT_W-1:0] tick_count_q;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  logic sync1_q, sync2_q, sync3_q;
  logic assync_edge;

  assign assync_edge = sync2_q & ~sync3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= assync;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= 8'd0;
      tick_en_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tick_en_q   <= tick_en_d;
      // Counter advances together with the tick_en pulse it accounts for.
      if (tick_en_d) begin
        tick_count_q <= tick_count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    // Judged against the current state: an edge in the same cycle as the
    // request that leaves IDLE is not delivered, and stop swallows a tick.
    tick_en_d   = assync_edge & (state_q != S_IDLE) & ~stop;

    unique case (state_q)
      S_IDLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end else if (burst) begin
          state_d     = S_BURST;
          remaining_d = BURST_LOAD;
        end else if (step) begin
          state_d = S_STEP;
        end
      end

      S_RUN: begin
        if (stop || start) begin
          state_d = S_IDLE;
        end
      end

      S_STEP: begin
        if (stop || assync_edge) begin
          state_d = S_IDLE;
        end
      end

      S_BURST: begin
        if (stop) begin
          state_d     = S_IDLE;
          remaining_d = 8'd0;
        end else if (assync_edge) begin
          remaining_d = remaining_q - 8'd1;
          // The tick that exhausts the burst also ends it.
          if (remaining_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tick_en    = tick_en_q;
  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tick_sequencer
//
// Two instances share all inputs: dut_a (CNT_W=8) and dut_w (CNT_W=2, for
// wrap-around), both with BURST_N=4. Directed scenario tasks are followed by
// a randomized run compared cycle-by-cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_tick_sequencer;

  localparam int BN = 4;

  logic clk = 1'b0;
  logic reset, start, step, burst, stop, assync;

  logic       tick_en_a, busy_a;
  logic [1:0] state_a;
  logic [7:0] count_a;
  logic       tick_en_w, busy_w;
  logic [1:0] state_w;
  logic [1:0] count_w;

  int total = 0;
  int bad   = 0;
  int seen_ticks = 0;

  // Behavioural reference: mode 0=IDLE 1=RUN 2=STEP 3=BURST.
  bit         m_hist[3];   // assync samples taken 1, 2 and 3 clock edges ago
  logic [1:0] m_mode;
  int         m_left;
  int         m_count;
  bit         m_tick;

  tick_sequencer #(.CNT_W(8), .BURST_N(BN)) dut_a (
    .clk(clk), .reset(reset), .start(start), .step(step), .burst(burst),
    .stop(stop), .assync(assync), .tick_en(tick_en_a), .state(state_a),
    .busy(busy_a), .tick_count(count_a)
  );

  tick_sequencer #(.CNT_W(2), .BURST_N(BN)) dut_w (
    .clk(clk), .reset(reset), .start(start), .step(step), .burst(burst),
    .stop(stop), .assync(assync), .tick_en(tick_en_w), .state(state_w),
    .busy(busy_w), .tick_count(count_w)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
    m_mode  = 2'd0;
    m_left  = 0;
    m_count = 0;
    m_tick  = 1'b0;
  endtask

  // One clock edge of the model. An assync rise becomes visible once it has
  // been sampled high two edges ago after being low three edges ago.
  task automatic model_step();
    bit ev;
    ev     = m_hist[1] && !m_hist[2];
    m_tick = ev && (m_mode != 2'd0) && !stop;
    case (m_mode)
      2'd0: begin
        if (stop) m_mode = 2'd0;
        else if (start) m_mode = 2'd1;
        else if (burst) begin m_mode = 2'd3; m_left = BN; end
        else if (step) m_mode = 2'd2;
      end
      2'd1: if (stop || start) m_mode = 2'd0;
      2'd2: if (stop || ev) m_mode = 2'd0;
      default: begin
        if (stop) m_mode = 2'd0;
        else if (ev) begin
          m_left--;
          if (m_left == 0) m_mode = 2'd0;
        end
      end
    endcase
    if (m_tick) m_count++;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = assync;
  endtask

  // Advance one clock; request pulses last exactly one cycle.
  task automatic cycle();
    if (reset) model_step();
    else model_reset();
    @(posedge clk);
    #1;
    if (tick_en_a) seen_ticks++;
    start = 1'b0; step = 1'b0; burst = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic rise(input int hi, input int lo);
    assync = 1'b1;
    repeat (hi) cycle();
    assync = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic do_reset();
    assync = 1'b0;
    reset  = 1'b0;
    model_reset();
    idle(2);
    reset = 1'b1;
    seen_ticks = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; step = 0; burst = 0; stop = 0; assync = 0;
    model_reset();
    #2;
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_a); end
    total++; if (tick_en_a !== 1'b0) begin bad++; $display("FAIL rst_tick_en got=%0b want=0", tick_en_a); end
    total++; if (count_a !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_a); end
    idle(2);
    reset = 1'b1;
    idle(2);
    total++; if (state_a !== 2'd0 || count_w !== 2'd0) begin bad++; $display("FAIL rst_release got=%0d/%0d want=0/0", state_a, count_w); end
  endtask

  task automatic test_run_toggle();
    do_reset();
    start = 1'b1; cycle();
    total++; if (state_a !== 2'd1 || busy_a !== 1'b1) begin bad++; $display("FAIL run_enter got=%0d busy=%0b want=1 busy=1", state_a, busy_a); end
    repeat (3) rise(3, 3);
    start = 1'b1; cycle();
    idle(4);
    total++; if (seen_ticks != 3) begin bad++; $display("FAIL run_ticks got=%0d want=3", seen_ticks); end
    total++; if (count_a !== 8'd3) begin bad++; $display("FAIL run_count got=%0d want=3", count_a); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL run_exit got=%0d want=0", state_a); end
  endtask

  task automatic test_step();
    do_reset();
    step = 1'b1; cycle();
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL step_enter got=%0d want=2", state_a); end
    repeat (2) rise(3, 3);
    total++; if (seen_ticks != 1) begin bad++; $display("FAIL step_ticks got=%0d want=1", seen_ticks); end
    total++; if (count_a !== 8'd1) begin bad++; $display("FAIL step_count got=%0d want=1", count_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL step_busy got=%0b want=0", busy_a); end
  endtask

  task automatic test_burst();
    bit check_next = 1'b0;
    bit checked    = 1'b0;
    do_reset();
    burst = 1'b1; cycle();
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL burst_enter got=%0d want=3", state_a); end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        assync = (c < 3);
        cycle();
        if (check_next) begin
          total++; if (state_a !== 2'd0) begin bad++; $display("FAIL burst_idle_after_4th got=%0d want=0", state_a); end
          check_next = 1'b0;
          checked    = 1'b1;
        end
        if (tick_en_a && seen_ticks == 4) check_next = 1'b1;
      end
    end
    total++; if (!checked) begin bad++; $display("FAIL burst_4th_tick_seen got=0 want=1"); end
    total++; if (seen_ticks != 4) begin bad++; $display("FAIL burst_ticks got=%0d want=4", seen_ticks); end
    total++; if (count_a !== 8'd4) begin bad++; $display("FAIL burst_count got=%0d want=4", count_a); end
  endtask

  task automatic test_priority_abort();
    do_reset();
    stop = 1'b1; start = 1'b1; cycle();
    total++; if (state_a !== 2'd0 || busy_a !== 1'b0) begin bad++; $display("FAIL prio_stop_start got=%0d want=0", state_a); end
    start = 1'b1; burst = 1'b1; step = 1'b1; cycle();
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL prio_start_first got=%0d want=1", state_a); end
    start = 1'b1; cycle();
    burst = 1'b1; step = 1'b1; cycle();
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL prio_burst_over_step got=%0d want=3", state_a); end
    repeat (2) rise(3, 3);
    total++; if (count_a !== 8'd2 || state_a !== 2'd3) begin bad++; $display("FAIL abort_pre count=%0d state=%0d want=2/3", count_a, state_a); end
    stop = 1'b1; cycle();
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d want=0", state_a); end
    repeat (2) rise(3, 3);
    total++; if (count_a !== 8'd2 || seen_ticks != 2) begin bad++; $display("FAIL abort_count got=%0d ticks=%0d want=2/2", count_a, seen_ticks); end
  endtask

  task automatic test_wrap();
    logic [1:0] got[$];
    logic [1:0] want[5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    do_reset();
    start = 1'b1; cycle();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        assync = (c < 3);
        cycle();
        if (tick_en_w) got.push_back(count_w);
      end
    end
    total++; if (got.size() != 5) begin bad++; $display("FAIL wrap_len got=%0d want=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      total++; if (got[i] !== want[i]) begin bad++; $display("FAIL wrap_seq[%0d] got=%0d want=%0d", i, got[i], want[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    burst = 1'b1; cycle();
    rise(3, 3);
    total++; if (count_a !== 8'd1) begin bad++; $display("FAIL midrst_pre got=%0d want=1", count_a); end
    // Leave an edge in flight in the synchroniser when reset hits.
    assync = 1'b1; cycle(); cycle();
    reset = 1'b0;
    model_reset();
    #1;
    total++; if (tick_en_a !== 1'b0 || state_a !== 2'd0 || busy_a !== 1'b0 || count_a !== 8'd0) begin
      bad++; $display("FAIL midrst_async got te=%0b st=%0d busy=%0b cnt=%0d want all 0", tick_en_a, state_a, busy_a, count_a);
    end
    cycle();
    reset = 1'b1;
    assync = 1'b0;
    seen_ticks = 0;
    idle(3);
    repeat (3) rise(3, 3);
    total++; if (seen_ticks != 0 || count_a !== 8'd0 || state_a !== 2'd0) begin
      bad++; $display("FAIL midrst_after ticks=%0d cnt=%0d st=%0d want 0/0/0", seen_ticks, count_a, state_a);
    end
  endtask

  task automatic test_release_high();
    assync = 1'b1;
    reset  = 1'b0;
    model_reset();
    idle(2);
    reset = 1'b1;
    seen_ticks = 0;
    idle(6);
    assync = 1'b0;
    idle(2);
    total++; if (seen_ticks != 0 || count_a !== 8'd0) begin bad++; $display("FAIL release_high ticks=%0d cnt=%0d want 0/0", seen_ticks, count_a); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      start = ($urandom_range(0, 19) == 0);
      step  = ($urandom_range(0, 11) == 0);
      burst = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) assync = ~assync;
      cycle();
      total++; if (tick_en_a !== m_tick || tick_en_w !== m_tick) begin
        bad++; if (bad < 20) $display("FAIL rnd_tick_en n=%0d got=%0b/%0b want=%0b", n, tick_en_a, tick_en_w, m_tick);
      end
      total++; if (state_a !== m_mode || state_w !== m_mode) begin
        bad++; if (bad < 20) $display("FAIL rnd_state n=%0d got=%0d/%0d want=%0d", n, state_a, state_w, m_mode);
      end
      total++; if (busy_a !== (m_mode != 2'd0) || busy_w !== (m_mode != 2'd0)) begin
        bad++; if (bad < 20) $display("FAIL rnd_busy n=%0d got=%0b/%0b want=%0b", n, busy_a, busy_w, (m_mode != 2'd0));
      end
      total++; if (count_a !== m_count[7:0] || count_w !== m_count[1:0]) begin
        bad++; if (bad < 20) $display("FAIL rnd_count n=%0d got=%0d/%0d want=%0d/%0d", n, count_a, count_w, m_count[7:0], m_count[1:0]);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_toggle();
    test_step();
    test_burst();
    test_priority_abort();
    test_wrap();
    test_reset_mid_burst();
    test_release_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
